ext_b_fifo: RTL and testbench
=============================

Name: ext_b_fifo

Overview:
- Parametrised successor to the single-stage AXI write-response (B) buffer in the mchan external unit.
- Stores up to DEPTH B beats (id, user, resp) in a circular FIFO with valid/ready on both sides.
- Optional fall-through mode for zero-latency pass when empty.
- Exposes occupancy and a sticky error-response monitor, so the mchan control logic can detect SLVERR/DECERR without snooping the B channel.

Parameters:
- ID_WIDTH, 4, width of B id field.
- USER_WIDTH, 6, width of B user field.
- DEPTH, 4, number of entries; power of two, >= 2.
- FALL_THROUGH, 0, 1 = empty FIFO forwards input to output combinationally; 0 = registered output only.
- CNT_WIDTH, 8, width of error counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- slave_valid_i  in  1  upstream B valid.
- slave_resp_i  in  2  upstream B resp.
- slave_id_i  in  ID_WIDTH  upstream B id.
- slave_user_i  in  USER_WIDTH  upstream B user.
- slave_ready_o  out  1  FIFO accepts beat.
- master_valid_o  out  1  downstream B valid.
- master_resp_o  out  2  downstream resp.
- master_id_o  out  ID_WIDTH  downstream id.
- master_user_o  out  USER_WIDTH  downstream user.
- master_ready_i  in  1  downstream ready.
- clr_err_i  in  1  synchronous clear of err_o / err_cnt_o.
- usage_o  out  $clog2(DEPTH+1)  stored entries.
- full_o  out  1  usage_o == DEPTH.
- empty_o  out  1  usage_o == 0.
- err_o  out  1  sticky: an error response was delivered downstream.
- err_cnt_o  out  CNT_WIDTH  count of error responses delivered downstream.

Behaviour:
- Reset values:
  - Pointers and usage are 0.
  - empty_o=1, full_o=0, slave_ready_o=1, master_valid_o=0.
  - master_resp/id/user_o=0.
  - err_o=0, err_cnt_o=0.
- Storage:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - usage is a separate counter.
  - Entry packs {id, user, resp}.
- Push = slave_valid_i & slave_ready_o. Pop = master_valid_o & master_ready_i.
- slave_ready_o = !full_o. It depends only on state, never on master_ready_i, so no combinational ready path exists.
- FALL_THROUGH=0:
  - master_valid_o = !empty_o; data = entry at read pointer.
  - Push-to-valid latency is 1 cycle.
- FALL_THROUGH=1, empty_o=1, slave_valid_i=1:
  - master_valid_o=1 and master data = slave data in the same cycle.
  - If master_ready_i=1, the beat bypasses storage and usage stays 0.
  - Otherwise the beat is written and appears registered next cycle.
- Simultaneous push and pop (not full): usage unchanged, both pointers advance.
- Full: slave_ready_o=0. A pop in the same cycle does not admit a push; slave_ready_o rises the following cycle.
- Ordering: strict FIFO; no reordering by ID.
- Output hold: master data stays stable while master_valid_o=1 and master_ready_i=0.
- Error monitor:
  - On pop with resp[1]=1 (SLVERR 2'b10 or DECERR 2'b11): err_o<=1 and err_cnt_o increments, saturating at 2^CNT_WIDTH-1.
  - clr_err_i alone: err_o<=0, err_cnt_o<=0.
  - clr_err_i together with an error pop: err_o<=1, err_cnt_o<=1.
- Asynchronous reset asserted mid-operation discards all stored entries immediately; outputs return to their reset values.

Optional Feature:
- EXT_B_FIFO_ERR_MON_EN defined: the error monitor is built as described above.
- Not defined: no error logic is built; err_o=0 and err_cnt_o=0 constantly; clr_err_i is ignored. Port list is identical in both cases.

Test Plan:
- Reset, then 4 pushes with master_ready_i=0 (DEPTH=4, ids 1..4):
  - full_o=1, usage_o=4, slave_ready_o=0.
  - Then master_ready_i=1: ids pop in order 1,2,3,4 on consecutive cycles; empty_o=1 after the 4th pop.
- FALL_THROUGH=0, empty, single push id=5 resp=0 with master_ready_i=1:
  - master_valid_o rises the cycle after the push.
  - id=5 is popped that cycle; usage_o returns to 0.
- FALL_THROUGH=1, empty, slave_valid_i=1 id=7 with master_ready_i=1:
  - master_valid_o=1, master_id_o=7 in the same cycle; usage_o stays 0.
- Full FIFO with simultaneous slave_valid_i=1 and a pop:
  - Push refused that cycle; usage_o=3 next cycle with slave_ready_o=1.
  - Retried beat is accepted.
- Pops with resp 2'b10, 2'b00, 2'b11:
  - err_cnt_o=2, err_o=1.
  - clr_err_i on the same cycle as a 2'b11 pop gives err_cnt_o=1.
  - With CNT_WIDTH=2 and 5 error pops, err_cnt_o saturates at 3.
- Assert rst_ni low for one half-cycle with usage_o=3:
  - usage_o=0, master_valid_o=0, err_cnt_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ext_b_fifo.sv
// ext_b_fifo: circular FIFO for AXI write-response (B) beats with optional
// fall-through and a sticky error-response monitor.
//
// Optional feature macro: EXT_B_FIFO_ERR_MON_EN
//   defined     -> err_o / err_cnt_o track SLVERR/DECERR beats delivered downstream
//   not defined -> err_o = 0, err_cnt_o = 0, clr_err_i ignored
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   slave_valid_i/resp_i/id_i/user_i   upstream B beat
//   slave_ready_o                      FIFO can accept a beat (state-only, = !full_o)
//   master_valid_o/resp_o/id_o/user_o  downstream B beat
//   master_ready_i                     downstream ready
//   clr_err_i                          synchronous clear of the error monitor
//   usage_o, full_o, empty_o           occupancy
//   err_o, err_cnt_o                   sticky error flag and saturating error count
module ext_b_fifo #(
   parameter int unsigned ID_WIDTH     = 4,
   parameter int unsigned USER_WIDTH   = 6,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned FALL_THROUGH = 0,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       slave_valid_i,
   input  logic [1:0]                 slave_resp_i,
   input  logic [ID_WIDTH-1:0]        slave_id_i,
   input  logic [USER_WIDTH-1:0]      slave_user_i,
   output logic                       slave_ready_o,
   output logic                       master_valid_o,
   output logic [1:0]                 master_resp_o,
   output logic [ID_WIDTH-1:0]        master_id_o,
   output logic [USER_WIDTH-1:0]      master_user_o,
   input  logic                       master_ready_i,
   input  logic                       clr_err_i,
   output logic [$clog2(DEPTH+1)-1:0] usage_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       err_o,
   output logic [CNT_WIDTH-1:0]       err_cnt_o
);

   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned UsageW = $clog2(DEPTH + 1);
   localparam int unsigned EntryW = ID_WIDTH + USER_WIDTH + 2;

   logic [EntryW-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [UsageW-1:0] usage_q, usage_d;

   logic              full, empty;
   logic              mvalid, bypass, push, pop, wr_en, rd_en;
   logic [EntryW-1:0] in_entry, out_entry;

   always_comb begin
      full      = (usage_q == UsageW'(DEPTH));
      empty     = (usage_q == '0);
      in_entry  = {slave_id_i, slave_user_i, slave_resp_i};
      out_entry = mem_q[rptr_q];
      mvalid    = !empty;
      bypass    = 1'b0;
      // Empty fall-through: present the incoming beat directly; it only skips
      // storage when it is consumed in the same cycle.
      if ((FALL_THROUGH != 0) && empty && slave_valid_i) begin
         mvalid    = 1'b1;
         out_entry = in_entry;
         bypass    = master_ready_i;
      end
      push  = slave_valid_i & !full;
      pop   = mvalid & master_ready_i;
      wr_en = push & !bypass;
      rd_en = pop & !bypass;
      unique case ({wr_en, rd_en})
         2'b10:   usage_d = usage_q + UsageW'(1);
         2'b01:   usage_d = usage_q - UsageW'(1);
         default: usage_d = usage_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usage_q <= '0;
         // Cleared so master data reads as zero out of reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         usage_q <= usage_d;
         if (wr_en) begin
            mem_q[wptr_q] <= in_entry;
            wptr_q        <= wptr_q + PtrW'(1);
         end
         if (rd_en) rptr_q <= rptr_q + PtrW'(1);
      end
   end

   assign slave_ready_o  = !full;
   assign master_valid_o = mvalid;
   assign master_id_o    = out_entry[EntryW-1 -: ID_WIDTH];
   assign master_user_o  = out_entry[2 +: USER_WIDTH];
   assign master_resp_o  = out_entry[1:0];
   assign usage_o        = usage_q;
   assign full_o         = full;
   assign empty_o        = empty;

`ifdef EXT_B_FIFO_ERR_MON_EN
   logic                 err_q;
   logic [CNT_WIDTH-1:0] err_cnt_q;
   logic                 err_pop;

   // resp[1] set covers both SLVERR and DECERR.
   assign err_pop = pop & out_entry[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else if (clr_err_i) begin
         // An error delivered in the clearing cycle is counted after the clear.
         err_q     <= err_pop;
         err_cnt_q <= err_pop ? CNT_WIDTH'(1) : '0;
      end else if (err_pop) begin
         err_q <= 1'b1;
         if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;
`else
   logic unused_clr_err;
   assign unused_clr_err = clr_err_i;
   assign err_o          = 1'b0;
   assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_ext_b_fifo.sv
// Bench for ext_b_fifo: u0 is registered-output (FALL_THROUGH=0, CNT_WIDTH=8),
// u1 is fall-through with a 2-bit error counter. Both see the same stimulus.
module tb_ext_b_fifo;

`ifdef EXT_B_FIFO_ERR_MON_EN
   localparam int Mon = 1;
`else
   localparam int Mon = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sv, mr, clr;
   logic [3:0] sid;
   logic [1:0] sresp;
   logic [5:0] suser;

   logic       srdy [2];
   logic       mv   [2];
   logic       fl   [2];
   logic       em   [2];
   logic       er   [2];
   logic [1:0] mresp[2];
   logic [3:0] mid  [2];
   logic [5:0] muser[2];
   logic [2:0] usage[2];
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic [7:0] cnt  [2];

   assign cnt[0] = cnt0;
   assign cnt[1] = {6'd0, cnt1};

   always #5 clk = ~clk;

   ext_b_fifo #(.ID_WIDTH(4), .USER_WIDTH(6), .DEPTH(4), .FALL_THROUGH(0), .CNT_WIDTH(8)) u0 (
      .clk_i(clk), .rst_ni(rst_n),
      .slave_valid_i(sv), .slave_resp_i(sresp), .slave_id_i(sid), .slave_user_i(suser),
      .slave_ready_o(srdy[0]),
      .master_valid_o(mv[0]), .master_resp_o(mresp[0]), .master_id_o(mid[0]),
      .master_user_o(muser[0]), .master_ready_i(mr),
      .clr_err_i(clr), .usage_o(usage[0]), .full_o(fl[0]), .empty_o(em[0]),
      .err_o(er[0]), .err_cnt_o(cnt0)
   );

   ext_b_fifo #(.ID_WIDTH(4), .USER_WIDTH(6), .DEPTH(4), .FALL_THROUGH(1), .CNT_WIDTH(2)) u1 (
      .clk_i(clk), .rst_ni(rst_n),
      .slave_valid_i(sv), .slave_resp_i(sresp), .slave_id_i(sid), .slave_user_i(suser),
      .slave_ready_o(srdy[1]),
      .master_valid_o(mv[1]), .master_resp_o(mresp[1]), .master_id_o(mid[1]),
      .master_user_o(muser[1]), .master_ready_i(mr),
      .clr_err_i(clr), .usage_o(usage[1]), .full_o(fl[1]), .empty_o(em[1]),
      .err_o(er[1]), .err_cnt_o(cnt1)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: one queue of {id,user,resp} per instance.
   logic [11:0] q0[$];
   logic [11:0] q1[$];
   logic        merr[2];
   int          mcnt[2];
   int          cmax[2];

   function automatic int qsz(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [11:0] qfront(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   initial begin
      cmax[0] = 255;
      cmax[1] = 3;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
               merr[i] = 1'b0;
               mcnt[i] = 0;
               chk($sformatf("u%0d rst ready", i), 32'(srdy[i]), 32'd1);
               chk($sformatf("u%0d rst valid", i), 32'(mv[i]), 32'd0);
               chk($sformatf("u%0d rst usage", i), 32'(usage[i]), 32'd0);
               chk($sformatf("u%0d rst empty", i), 32'(em[i]), 32'd1);
               chk($sformatf("u%0d rst full", i), 32'(fl[i]), 32'd0);
               chk($sformatf("u%0d rst data", i), 32'({mid[i], muser[i], mresp[i]}), 32'd0);
               chk($sformatf("u%0d rst err", i), 32'(er[i]), 32'd0);
               chk($sformatf("u%0d rst cnt", i), 32'(cnt[i]), 32'd0);
            end
         end else begin
            for (int i = 0; i < 2; i++) begin
               int          sz;
               logic        ev, push, pop, epop;
               logic [11:0] ed, din;
               sz  = qsz(i);
               din = {sid, suser, sresp};
               ed  = '0;
               ev  = 1'b0;
               if (sz > 0) begin
                  ev = 1'b1;
                  ed = qfront(i);
               end else if (i == 1 && sv) begin
                  ev = 1'b1;
                  ed = din;
               end
               chk($sformatf("u%0d ready", i), 32'(srdy[i]), 32'(sz < 4));
               chk($sformatf("u%0d valid", i), 32'(mv[i]), 32'(ev));
               chk($sformatf("u%0d usage", i), 32'(usage[i]), 32'(sz));
               chk($sformatf("u%0d full", i), 32'(fl[i]), 32'(sz == 4));
               chk($sformatf("u%0d empty", i), 32'(em[i]), 32'(sz == 0));
               if (ev) chk($sformatf("u%0d data", i), 32'({mid[i], muser[i], mresp[i]}), 32'(ed));
               chk($sformatf("u%0d err", i), 32'(er[i]), 32'(merr[i]));
               chk($sformatf("u%0d cnt", i), 32'(cnt[i]), 32'(mcnt[i]));
               push = sv && (sz < 4);
               pop  = ev && mr;
               epop = pop && ed[1];
               if (pop && sz > 0) begin
                  if (i == 0) void'(q0.pop_front());
                  else        void'(q1.pop_front());
               end
               if (push && !(pop && sz == 0)) begin
                  if (i == 0) q0.push_back(din);
                  else        q1.push_back(din);
               end
`ifdef EXT_B_FIFO_ERR_MON_EN
               if (clr) begin
                  merr[i] = epop;
                  mcnt[i] = epop ? 1 : 0;
               end else if (epop) begin
                  merr[i] = 1'b1;
                  if (mcnt[i] < cmax[i]) mcnt[i]++;
               end
`endif
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [3:0] id, input logic [1:0] resp,
                        input logic rdy, input logic c);
      @(posedge clk);
      #1;
      sv    = v;
      sid   = id;
      sresp = resp;
      suser = {id, resp};
      mr    = rdy;
      clr   = c;
      #1;
   endtask

   initial begin
      sv = 1'b0; sid = '0; sresp = '0; suser = '0; mr = 1'b0; clr = 1'b0;
      #12;
      chk("reset usage", 32'(usage[0]), 32'd0);
      chk("reset empty", 32'(em[0]), 32'd1);
      chk("reset ready", 32'(srdy[0]), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Fill with ids 1..4 while stalled, then drain in order.
      for (int k = 1; k <= 4; k++) drive(1'b1, 4'(k), 2'b00, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("fill full", 32'(fl[0]), 32'd1);
      chk("fill usage", 32'(usage[0]), 32'd4);
      chk("fill ready", 32'(srdy[0]), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
         chk($sformatf("drain id %0d", k), 32'(mid[0]), 32'(k));
      end
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("drain empty", 32'(em[0]), 32'd1);

      // Single push: registered latency on u0, bypass on u1.
      drive(1'b1, 4'd5, 2'b00, 1'b1, 1'b0);
      chk("lat push cycle u0 valid", 32'(mv[0]), 32'd0);
      chk("bypass u1 id5", 32'(mid[1]), 32'd5);
      drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
      chk("lat next u0 valid", 32'(mv[0]), 32'd1);
      chk("lat next u0 id", 32'(mid[0]), 32'd5);
      chk("bypass u1 usage", 32'(usage[1]), 32'd0);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("lat u0 usage back", 32'(usage[0]), 32'd0);

      drive(1'b1, 4'd7, 2'b00, 1'b1, 1'b0);
      chk("ft u1 valid", 32'(mv[1]), 32'd1);
      chk("ft u1 id7", 32'(mid[1]), 32'd7);
      drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
      chk("ft u1 usage", 32'(usage[1]), 32'd0);

      // Full with push + pop in the same cycle: push refused, retried next cycle.
      for (int k = 8; k <= 11; k++) drive(1'b1, 4'(k), 2'b00, 1'b0, 1'b0);
      drive(1'b1, 4'd12, 2'b00, 1'b1, 1'b0);
      chk("full pop ready", 32'(srdy[0]), 32'd0);
      drive(1'b1, 4'd12, 2'b00, 1'b0, 1'b0);
      chk("after pop usage", 32'(usage[0]), 32'd3);
      chk("after pop ready", 32'(srdy[0]), 32'd1);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("retry usage", 32'(usage[0]), 32'd4);
      for (int k = 0; k < 4; k++) drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);

      // Error monitor.
      drive(1'b1, 4'd1, 2'b10, 1'b0, 1'b0);
      drive(1'b1, 4'd2, 2'b00, 1'b0, 1'b0);
      drive(1'b1, 4'd3, 2'b11, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("err cnt 2", 32'(cnt0), 32'(Mon * 2));
      chk("err flag", 32'(er[0]), 32'(Mon));
      drive(1'b1, 4'd4, 2'b11, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b1);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("clr with err pop", 32'(cnt0), 32'(Mon));
      for (int k = 0; k < 5; k++) drive(1'b1, 4'(k), 2'b10, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("cnt saturate u1", 32'(cnt1), 32'(Mon * 3));
      chk("cnt u0", 32'(cnt0), 32'(Mon * 6));

      // Asynchronous reset mid-operation.
      for (int k = 1; k <= 3; k++) drive(1'b1, 4'(k), 2'b11, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      chk("pre-reset usage", 32'(usage[0]), 32'd3);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async usage", 32'(usage[0]), 32'd0);
      chk("async valid", 32'(mv[0]), 32'd0);
      chk("async cnt", 32'(cnt0), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      drive(1'b1, 4'd6, 2'b01, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
      chk("post-reset id", 32'(mid[0]), 32'd6);
      drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
